// File: rtl/k423_ex_div_seq.sv
// Radix-2 restoring divide sequencer for RV32M DIV/DIVU/REM/REMU in EX.
// Optional early-out for |rs1| < |rs2| is enabled by defining K423_DIV_EARLY_OUT_EN.
//
// state | meaning
// IDLE  | waiting for a divide op; accepts when req_vld_i & ~flush_i
// CALC  | one quotient bit per cycle, XLEN cycles
// DONE  | result on res_o, held until res_rdy_i, flush or dropped request
module k423_ex_div_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            req_vld_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  input  logic            res_rdy_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] res_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   dvd_q;
  logic [XLEN-1:0]   dvs_q;
  logic [XLEN:0]     rem_q;
  logic              q_neg_q, r_neg_q, is_rem_q;

  logic              is_signed, accept, div_zero, ovf, early;
  logic [XLEN-1:0]   mag1, mag2;
  logic [XLEN+1:0]   trial;
  logic [XLEN-1:0]   q_val, r_val;

  assign is_signed = ~op_i[0];
  assign accept    = (state_q == S_IDLE) & req_vld_i & ~flush_i;
  assign div_zero  = (rs2_i == '0);
  assign ovf       = is_signed & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == '1);
  assign mag1      = (is_signed & rs1_i[XLEN-1]) ? (~rs1_i + 1'b1) : rs1_i;
  assign mag2      = (is_signed & rs2_i[XLEN-1]) ? (~rs2_i + 1'b1) : rs2_i;

`ifdef K423_DIV_EARLY_OUT_EN
  assign early = (mag1 < mag2);
`else
  assign early = 1'b0;
`endif

  // Remainder stays below the divisor, so the top bit of {rem, msb} is 0 and
  // bit XLEN+1 of the difference is a clean borrow flag.
  assign trial = {rem_q, dvd_q[XLEN-1]} - {2'b00, dvs_q};

  always_comb begin
    state_d = state_q;
    busy_o  = (state_q != S_IDLE);
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = (div_zero | ovf | early) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (flush_i | ~req_vld_i) state_d = S_IDLE;
        else if (cnt_q == '0)     state_d = S_DONE;
      end
      S_DONE: begin
        done_o = 1'b1;
        if (flush_i | ~req_vld_i | res_rdy_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    q_val = q_neg_q ? (~dvd_q + 1'b1) : dvd_q;
    r_val = r_neg_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
    res_o = '0;
    if (done_o) res_o = is_rem_q ? r_val : q_val;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_rem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_rem_q <= op_i[1];
        dvs_q    <= mag2;
        if (div_zero) begin
          dvd_q   <= '1;
          rem_q   <= {1'b0, rs1_i};
          q_neg_q <= 1'b0;
          r_neg_q <= 1'b0;
        end else if (ovf) begin
          dvd_q   <= rs1_i;
          rem_q   <= '0;
          q_neg_q <= 1'b0;
          r_neg_q <= 1'b0;
        end else begin
          // early-out keeps the quotient at 0 and parks |rs1| as the remainder
          dvd_q   <= early ? '0 : mag1;
          rem_q   <= early ? {1'b0, mag1} : '0;
          q_neg_q <= is_signed & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
          r_neg_q <= is_signed & rs1_i[XLEN-1];
          cnt_q   <= CNT_W'(XLEN-1);
        end
      end else if (state_q == S_CALC) begin
        if (trial[XLEN+1]) begin
          rem_q <= {rem_q[XLEN-1:0], dvd_q[XLEN-1]};
          dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
        end else begin
          rem_q <= trial[XLEN:0];
          dvd_q <= {dvd_q[XLEN-2:0], 1'b1};
        end
        if (cnt_q != '0) cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: doc/k423_ex_div_seq.md
Name: k423_ex_div_seq

Overview:
- Multi-cycle sequencer for RV32M divide/remainder (DIV, DIVU, REM, REMU) in the EX stage.
- Owns a radix-2 restoring divide datapath: operand conditioning, one quotient bit per cycle, sign fix-up.
- Supplies the EX stage "done" term so EX holds the instruction until the result is ready and WB accepts it.
- Sits beside ALU/LSU/BJU; its result is muxed onto the EX rd path when a divide op is in EX.

Parameters:
- XLEN, 32, operand/result width; must be a power of 2, 8 or larger.
- CNT_W, $clog2(XLEN), iteration counter width.

Ports:
- clk_i  input  1  core clock
- rst_n_i  input  1  reset, synchronous, active-low
- req_vld_i  input  1  divide op valid in EX; held high until done_o & res_rdy_i
- op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; stable while req_vld_i high
- rs1_i  input  XLEN  dividend; stable while req_vld_i high
- rs2_i  input  XLEN  divisor; stable while req_vld_i high
- flush_i  input  1  pipeline flush; aborts any operation
- res_rdy_i  input  1  downstream (WB) ready
- busy_o  output  1  high in CALC or DONE
- done_o  output  1  result valid this cycle
- res_o  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU); 0 when done_o low

Behaviour:
- One clock, clk_i. rst_n_i is synchronous and active-low. All state updates occur on the rising edge.
- Reset: state IDLE, counter 0, internal registers 0. done_o=0, busy_o=0, res_o=0.
- States: IDLE, CALC, DONE.
- IDLE, with req_vld_i=1 and flush_i=0 (accept cycle T):
  - Divisor==0: latch quotient=all-ones, remainder=rs1_i; go to DONE.
  - op DIV or REM with rs1_i=0x80000000 (MSB only) and rs2_i=all-ones: latch quotient=rs1_i, remainder=0; go to DONE.
  - Otherwise:
    - Latch |rs1|, |rs2|. Take magnitudes for signed ops, raw values for unsigned ops.
    - Latch q_neg = sign(rs1)^sign(rs2) and r_neg = sign(rs1). Both are forced 0 for unsigned ops.
    - Clear the partial remainder, set the counter to XLEN-1, go to CALC.
- CALC, one iteration per cycle:
  - Partial remainder width is XLEN+1.
  - Per cycle: trial = {rem, dividend MSB} - divisor.
  - If trial is non-negative: rem = trial, q bit = 1. Otherwise rem is shifted only, q bit = 0.
  - The dividend/quotient register shifts left by 1 each cycle.
  - On counter==0, go to DONE; otherwise decrement the counter.
- CALC is exactly XLEN cycles. Normal latency: done_o first high at T+XLEN+1 (T+33 for XLEN=32).
- DONE:
  - done_o=1.
  - res_o is formed combinationally from the registers: quotient negated if q_neg, remainder negated if r_neg.
  - Negation is two's complement, XLEN bits, and wraps.
  - If res_rdy_i=1, go to IDLE. Otherwise hold DONE with res_o stable.
- Special-case latency: done_o at T+1.
- flush_i=1 in any state: next state IDLE, and done_o is low from the next cycle.
  - A request is not accepted while flush_i is high.
  - In DONE, flush_i wins over res_rdy_i; the result is dropped.
- req_vld_i dropping in CALC or DONE without a flush: abort to IDLE next cycle. This is a protocol error, but recovery is required.
- Back-to-back ops: the DONE→IDLE handoff costs one cycle. The next op's accept cycle is the cycle after the DONE handshake.
- busy_o = (state != IDLE).
- EX integration: ex_stage_done = ~div_op | done_o.

Optional Feature:
- Macro: K423_DIV_EARLY_OUT_EN.
- Defined: in IDLE, a non-special op with |rs1| < |rs2| (unsigned magnitude compare) skips CALC.
  - It latches quotient=0, remainder=|rs1| with sign flags as normal, and reaches DONE at T+1.
  - Example: REM -3,7 gives -3.
- Undefined: the compare logic is absent and all non-special ops take XLEN CALC cycles.

Test Plan:
- DIVU 100/7, res_rdy_i=1 → done_o first high at T+33, res_o=14; busy_o high T+1..T+33; IDLE at T+34.
- REM -7 (0xFFFFFFF9) / 2 → res_o=0xFFFFFFFF (-1). DIV same operands → res_o=0xFFFFFFFD (-3).
- DIV x/0 → done_o at T+1, res_o=0xFFFFFFFF. REMU 5/0 → res_o=5. DIV 0x80000000/-1 → res_o=0x80000000 at T+1. REM same operands → 0.
- DIVU 100/7 with res_rdy_i=0 for 5 cycles after T+33 → done_o and res_o=14 held stable; IDLE on the cycle after res_rdy_i rises.
- flush_i pulsed at T+10 during CALC → IDLE at T+11, done_o never asserts. A new DIVU 9/3 accepted next returns 3 at its T+33. rst_n_i=0 mid-CALC → all outputs 0 next cycle.
- With K423_DIV_EARLY_OUT_EN: DIVU 3/7 → done_o at T+1, res_o=0; REMU 3/7 → res_o=3. Without the macro, the same ops complete at T+33 with identical results.
